// File: rtl/a4092_spi_pkg.sv
// Shared types and constants for the A4092 SPI boot-ROM reader.
package a4092_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_STREAM,
    ST_DESELECT
  } state_e;

  localparam logic [7:0]  READ_OPCODE = 8'h03;
  localparam int unsigned CMD_BITS    = 8;
  localparam int unsigned ADDR_BITS   = 24;
  localparam int unsigned DATA_BITS   = 32;
  localparam int unsigned NBITS_W     = 6;

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI bit engine: SCK divider, bit counter, MOSI shifter, MISO capture.
// A start on the cycle that done_c_o is high chains the next field with no gap.
module spi_shift_engine
  import a4092_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV = 1
) (
  input  logic               CLK_50M,
  input  logic               IORST_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [NBITS_W-1:0] nbits_i,
  input  logic [31:0]        tx_i,
  input  logic               miso_i,
  output logic               sck_o,
  output logic               mosi_o,
  output logic               active_o,
  output logic               done_c_o,
  output logic               stop_c_o,
  output logic [31:0]        rx_o
);

  localparam int unsigned      DIV_W      = 4;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCK_DIV - 1);

  logic               active_q, active_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NBITS_W-1:0] cnt_q, cnt_d;
  logic [31:0]        sr_q, sr_d;
  logic [31:0]        rx_q, rx_d;
  logic               tick;

  // Half-period timing, shifting and abort handling.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    mosi_d   = mosi_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    rx_d     = rx_q;
    tick     = (div_q == '0);
    done_c_o = active_q & tick & sck_q & (cnt_q == NBITS_W'(1)) & ~abort_i;
    stop_c_o = abort_i & (~active_q | ~sck_q | tick);
    if (abort_i) begin
      // Let a high SCK phase finish before stopping with SCK low.
      if (stop_c_o) begin
        active_d = 1'b0;
        sck_d    = 1'b0;
        mosi_d   = 1'b0;
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end else if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b0;
      div_d    = DIV_RELOAD;
      cnt_d    = nbits_i;
      sr_d     = tx_i;
      mosi_d   = tx_i[31];
    end else if (active_q) begin
      if (tick) begin
        div_d = DIV_RELOAD;
        sck_d = ~sck_q;
        if (!sck_q) begin
          rx_d = {rx_q[30:0], miso_i};
        end else begin
          cnt_d  = cnt_q - NBITS_W'(1);
          sr_d   = {sr_q[30:0], 1'b0};
          mosi_d = sr_q[30];
          if (cnt_q == NBITS_W'(1)) begin
            active_d = 1'b0;
            mosi_d   = 1'b0;
          end
        end
      end else begin
        div_d = div_q - DIV_W'(1);
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      rx_q     <= rx_d;
    end
  end

  assign sck_o    = sck_q;
  assign mosi_o   = mosi_q;
  assign active_o = active_q;
  assign rx_o     = rx_q;

endmodule

// File: rtl/spi_rom_reader.sv
// Zorro III boot-ROM longword reader over SPI flash, with sequential streaming.
module spi_rom_reader
  import a4092_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV        = 1,
  parameter int unsigned CS_HIGH_MIN    = 3,
  parameter int unsigned STREAM_TIMEOUT = 64,
  parameter logic [7:0]  READ_CMD       = READ_OPCODE
) (
  input  logic        CLK_50M,
  input  logic        IORST_n,
  input  logic        req,
  input  logic [21:0] addr,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        SPI_CS_n
);

  localparam int unsigned TMR_W = 16;

  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [21:0]        last_addr_q, last_addr_d;
  logic               sv_q, sv_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               cs_n_q, busy_q;
  logic               start_c, abort_c, hit_c;
  logic [NBITS_W-1:0] nbits_c;
  logic [31:0]        tx_c;
  logic               eng_active, eng_done, eng_stop;
  logic [31:0]        eng_rx;

  spi_shift_engine #(.SCK_DIV(SCK_DIV)) u_eng (
    .CLK_50M  (CLK_50M),
    .IORST_n  (IORST_n),
    .start_i  (start_c),
    .abort_i  (abort_c),
    .nbits_i  (nbits_c),
    .tx_i     (tx_c),
    .miso_i   (SPI_MISO),
    .sck_o    (SPI_CLK),
    .mosi_o   (SPI_MOSI),
    .active_o (eng_active),
    .done_c_o (eng_done),
    .stop_c_o (eng_stop),
    .rx_o     (eng_rx)
  );

  // Next-state, engine control and output updates.
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    rdata_d     = rdata_q;
    last_addr_d = last_addr_q;
    sv_d        = sv_q;
    tmr_d       = tmr_q + TMR_W'(1);
    start_c     = 1'b0;
    abort_c     = 1'b0;
    nbits_c     = NBITS_W'(DATA_BITS);
    tx_c        = '0;
    hit_c       = sv_q & (last_addr_q != '1) & (addr == last_addr_q + 22'd1);
    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (req) state_d = ST_CMD;
      end
      ST_CMD, ST_ADDR, ST_DATA: begin
        if (!req) begin
          abort_c = 1'b1;
          if (eng_stop) begin
            state_d = ST_DESELECT;
            sv_d    = 1'b0;
            tmr_d   = '0;
          end
        end else if (state_q == ST_CMD && !eng_active) begin
          start_c = 1'b1;
          nbits_c = NBITS_W'(CMD_BITS);
          tx_c    = {READ_CMD, 24'h000000};
        end else if (eng_done) begin
          if (state_q == ST_CMD) begin
            start_c = 1'b1;
            nbits_c = NBITS_W'(ADDR_BITS);
            tx_c    = {addr, 2'b00, 8'h00};
            state_d = ST_ADDR;
          end else if (state_q == ST_ADDR) begin
            start_c = 1'b1;
            state_d = ST_DATA;
          end else begin
            state_d     = ST_HOLD;
            last_addr_d = addr;
            sv_d        = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (!ack_q) begin
          if (req) begin
            ack_d   = 1'b1;
            rdata_d = eng_rx;
          end else begin
            state_d = ST_DESELECT;
            sv_d    = 1'b0;
            tmr_d   = '0;
          end
        end else if (!req) begin
          ack_d   = 1'b0;
          state_d = ST_STREAM;
          tmr_d   = '0;
        end
      end
      ST_STREAM: begin
        if (req) begin
          if (hit_c) begin
            start_c = 1'b1;
            state_d = ST_DATA;
          end else begin
            state_d = ST_DESELECT;
            sv_d    = 1'b0;
            tmr_d   = '0;
          end
        end else if (tmr_q == TMR_W'(STREAM_TIMEOUT - 2)) begin
          // CS_n lags the state by one cycle, so it stays low STREAM_TIMEOUT cycles.
          state_d = ST_DESELECT;
          sv_d    = 1'b0;
          tmr_d   = '0;
        end
      end
      ST_DESELECT: begin
        if (tmr_q == TMR_W'(CS_HIGH_MIN - 1)) state_d = req ? ST_CMD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and output registers; reset drops CS_n immediately.
  always_ff @(posedge CLK_50M or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      last_addr_q <= '0;
      sv_q        <= 1'b0;
      tmr_q       <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      last_addr_q <= last_addr_d;
      sv_q        <= sv_d;
      tmr_q       <= tmr_d;
      cs_n_q      <= ~(state_q inside {ST_CMD, ST_ADDR, ST_DATA, ST_HOLD, ST_STREAM});
      busy_q      <= (state_q != ST_IDLE);
    end
  end

  assign rdata    = rdata_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign SPI_CS_n = cs_n_q;

endmodule

// File: tb/tb_spi_rom_reader.sv
// Directed + randomized bench for spi_rom_reader with a behavioural SPI flash.
module tb_spi_rom_reader;

  logic        CLK_50M = 1'b0;
  logic        IORST_n = 1'b0;
  logic        req = 1'b0;
  logic [21:0] addr = '0;
  logic [31:0] rdata;
  logic        ack, busy, SPI_CLK, SPI_MOSI, SPI_CS_n;
  logic        SPI_MISO = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_rom_reader dut (
    .CLK_50M  (CLK_50M),
    .IORST_n  (IORST_n),
    .req      (req),
    .addr     (addr),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .SPI_CLK  (SPI_CLK),
    .SPI_MOSI (SPI_MOSI),
    .SPI_MISO (SPI_MISO),
    .SPI_CS_n (SPI_CS_n)
  );

  always #10 CLK_50M = ~CLK_50M;

  // Flash contents: fixed test word at byte 4, hashed pattern elsewhere.
  logic [7:0] seed = 8'h00;
  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [31:0] h;
    h = {8'h00, a} * 32'h9E3779B1;
    case (a)
      24'h000004: return 8'hDE;
      24'h000005: return 8'hAD;
      24'h000006: return 8'hBE;
      24'h000007: return 8'hEF;
      default:    return h[23:16] ^ seed;
    endcase
  endfunction

  // Behavioural SPI flash: 32 command/address bits, then an endless data stream.
  int          bitcnt = 0;
  int          cmd_count = 0;
  int          cs_rises = 0;
  int          ack_rises = 0;
  int          cs_high_len = 0;
  time         t_cs_rise = 0;
  logic [31:0] sh = '0;
  logic [7:0]  seen_cmd = '0;
  logic [23:0] seen_addr = '0;

  always @(posedge SPI_CLK) begin
    if (!SPI_CS_n) begin
      if (bitcnt < 32) sh = {sh[30:0], SPI_MOSI};
      bitcnt++;
      if (bitcnt == 32) begin
        cmd_count++;
        seen_cmd  = sh[31:24];
        seen_addr = sh[23:0];
      end
    end
  end

  always @(negedge SPI_CLK) begin
    int d;
    logic [7:0] b;
    if (!SPI_CS_n && bitcnt >= 32) begin
      d = bitcnt - 32;
      b = byte_at(seen_addr + 24'(d / 8));
      SPI_MISO = b[3'(7 - (d % 8))];
    end
  end

  always @(posedge SPI_CS_n) begin
    bitcnt = 0;
    cs_rises++;
    t_cs_rise = $time;
  end

  always @(negedge SPI_CS_n) cs_high_len = int'(($time - t_cs_rise) / 20);
  always @(posedge ack) ack_rises++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One longword read: latency from the sampling edge of req to ack, data, command traffic.
  task automatic do_read(input logic [21:0] a, input int exp_lat, input bit exp_cold, input string tag);
    int n;
    int cmd0;
    int csr0;
    logic [23:0] ba;
    cmd0 = cmd_count;
    csr0 = cs_rises;
    ba   = {a, 2'b00};
    @(negedge CLK_50M);
    req  = 1'b1;
    addr = a;
    @(posedge CLK_50M);
    n = 0;
    while (n < 1000) begin
      @(posedge CLK_50M);
      n++;
      #1;
      if (ack) break;
    end
    check($sformatf("%s_lat", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s_rdata", tag), rdata,
          {byte_at(ba), byte_at(ba + 24'd1), byte_at(ba + 24'd2), byte_at(ba + 24'd3)});
    if (exp_cold) begin
      check($sformatf("%s_ncmd", tag), 32'(cmd_count), 32'(cmd0 + 1));
      check($sformatf("%s_opcode", tag), 32'(seen_cmd), 32'h03);
      check($sformatf("%s_addr", tag), 32'(seen_addr), 32'(ba));
    end else begin
      check($sformatf("%s_ncmd", tag), 32'(cmd_count), 32'(cmd0));
      check($sformatf("%s_csrise", tag), 32'(cs_rises), 32'(csr0));
    end
    @(negedge CLK_50M);
    req = 1'b0;
    @(posedge CLK_50M);
    #1;
    check($sformatf("%s_ackfall", tag), 32'(ack), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acks0;
    bit open;
    logic [21:0] prev, a;
    logic [31:0] rsave;
    int lat;

    seed = 8'($urandom);

    // Reset values.
    repeat (3) @(posedge CLK_50M);
    #1;
    check("rst_cs_n", 32'(SPI_CS_n), 32'h1);
    check("rst_sck",  32'(SPI_CLK),  32'h0);
    check("rst_mosi", 32'(SPI_MOSI), 32'h0);
    check("rst_ack",  32'(ack),      32'h0);
    check("rst_rdata", rdata,        32'h0);
    check("rst_busy", 32'(busy),     32'h0);
    @(negedge CLK_50M);
    IORST_n = 1'b1;
    repeat (2) @(posedge CLK_50M);

    // Cold read, sequential hit, then a miss that must deselect first.
    do_read(22'h000001, 130, 1'b1, "cold");
    check("cold_word", rdata, 32'hDEADBEEF);
    do_read(22'h000002, 65, 1'b0, "hit");
    do_read(22'h100000, 133, 1'b1, "miss");
    check("miss_cs_high_min", 32'(cs_high_len >= 3), 32'h1);

    // Stream timeout: CS_n rises after the idle window, busy three cycles later.
    n = 0;
    while (n < 300) begin
      @(posedge CLK_50M);
      n++;
      #1;
      if (SPI_CS_n) break;
    end
    check("timeout_cs", 32'(n), 32'd64);
    n = 0;
    while (n < 50) begin
      @(posedge CLK_50M);
      n++;
      #1;
      if (!busy) break;
    end
    check("timeout_busy", 32'(n), 32'd3);

    // Abort in the address phase.
    rsave = rdata;
    acks0 = ack_rises;
    @(negedge CLK_50M);
    req  = 1'b1;
    addr = 22'($urandom);
    n = 0;
    while (n < 300 && bitcnt < 20) begin
      @(posedge CLK_50M);
      n++;
    end
    @(negedge CLK_50M);
    req = 1'b0;
    repeat (10) @(posedge CLK_50M);
    #1;
    check("abort_sck",   32'(SPI_CLK),   32'h0);
    check("abort_cs_n",  32'(SPI_CS_n),  32'h1);
    check("abort_noack", 32'(ack_rises), 32'(acks0));
    check("abort_rdata", rdata,          rsave);
    do_read(22'($urandom), 130, 1'b1, "post_abort");

    // Top address never streams into address zero.
    repeat (100) @(posedge CLK_50M);
    do_read(22'h3FFFFF, 130, 1'b1, "top");
    do_read(22'h000000, 133, 1'b1, "wrap");
    repeat (100) @(posedge CLK_50M);

    // Asynchronous reset in the data phase.
    @(negedge CLK_50M);
    req  = 1'b1;
    addr = 22'($urandom);
    n = 0;
    while (n < 300 && bitcnt < 40) begin
      @(posedge CLK_50M);
      n++;
    end
    @(negedge CLK_50M);
    #2;
    IORST_n = 1'b0;
    #1;
    check("arst_cs_n", 32'(SPI_CS_n), 32'h1);
    check("arst_sck",  32'(SPI_CLK),  32'h0);
    check("arst_ack",  32'(ack),      32'h0);
    req = 1'b0;
    @(negedge CLK_50M);
    IORST_n = 1'b1;
    repeat (2) @(posedge CLK_50M);

    // Random mix of sequential and scattered reads with random gaps.
    open = 1'b0;
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      if (open && $urandom_range(0, 2) != 0) a = prev + 22'd1;
      else a = 22'($urandom);
      if (!open) lat = 130;
      else if (prev != 22'h3FFFFF && a == prev + 22'd1) lat = 65;
      else lat = 133;
      do_read(a, lat, (lat != 65), $sformatf("rnd%0d", i));
      prev = a;
      if ($urandom_range(0, 3) == 0) begin
        repeat (100) @(posedge CLK_50M);
        open = 1'b0;
      end else begin
        repeat ($urandom_range(0, 20)) @(posedge CLK_50M);
        open = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
